// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU R/W/Done handshake.
// A level-held read or write request is captured in IDLE, serviced against an
// internal word-addressed RAM after WAIT_STATES extra cycles, acknowledged with
// a one-cycle Done pulse, and then the responder waits for R/W to drop before
// it will accept another request.
//
// Timing: a request captured at edge k gives Done for the cycle between edges
// k+1+WAIT_STATES and k+2+WAIT_STATES. BUSY therefore always lasts
// WAIT_STATES+1 edges, so a WAIT_STATES=0 instance still answers one edge
// after capture.
module mem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              R,
    input  logic              W,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              Done,
    output logic              err,
    output logic              busy
);

    // Word index width (byte address minus the two ignored low bits).
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(WAIT_STATES);
    // One bit wider than the index so DEPTH itself is representable.
    localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone,
        StRelease
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                op_r;
    logic                op_w;
    logic                illegal_q;
    logic [MEM_AW-1:0]   idx_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [IDX_W-1:0]    req_idx;
    logic [MEM_AW-1:0]   mem_idx;
    logic                idx_oob;
    logic                req_illegal;
    logic                commit;
    logic                unused_bits;

    // RAM is deliberately left without reset so contents survive rst.
    logic [DATA_W-1:0]   mem [DEPTH];

    assign req_idx     = addr[ADDR_W-1:2];
    assign mem_idx     = req_idx[MEM_AW-1:0];
    assign idx_oob     = ({1'b0, req_idx} >= DEPTH_LIM);
    assign req_illegal = (R & W) | idx_oob;

    // Commit happens on the edge that moves BUSY into DONE.
    assign commit = (state == StBusy) && (cnt == '0);

    // Byte-offset bits and index bits above the RAM range are never used
    // for addressing; the range check above covers the latter.
    assign unused_bits = ^{addr[1:0], req_idx[IDX_W-1:MEM_AW]};

    // RAM write port: only a legal write commits, so an out-of-range index
    // can never alias onto a real word through truncation.
    always_ff @(posedge clk) begin
        if (commit && op_w && !illegal_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Handshake FSM with registered Done/busy/err/rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= '0;
            Done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            op_r      <= 1'b0;
            op_w      <= 1'b0;
            illegal_q <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (R | W) begin
                        // Snapshot the whole request; later input changes are ignored.
                        op_r      <= R;
                        op_w      <= W;
                        idx_q     <= mem_idx;
                        wdata_q   <= wdata;
                        illegal_q <= req_illegal;
                        cnt       <= CNT_INIT;
                        busy      <= 1'b1;
                        state     <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt == '0) begin
                        state <= StDone;
                        Done  <= 1'b1;
                        err   <= illegal_q;
                        if (op_r && !illegal_q) begin
                            rdata <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StDone: begin
                    // err is only meaningful alongside Done.
                    err   <= 1'b0;
                    state <= StRelease;
                end
                StRelease: begin
                    // Never accept here: the initiator may still be holding
                    // the request it has just been told is complete.
                    if (!(R | W)) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES=2 and 0) checked
// against a word-array model of the memory and of the rdata register.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        r0, w0, r1, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [31:0] rd0, rd1;
    logic        done0, done1, err0, err1, busy0, busy1;

    int checks;
    int failures;

    // Behavioural model: per-instance memory and last successfully read word.
    logic [31:0] mdl_mem [0:1][0:1023];
    logic [31:0] mdl_rd  [0:1];

    mem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(2)
    ) u_ws2 (
        .clk(clk), .rst(rst), .R(r0), .W(w0), .addr(a0), .wdata(d0),
        .rdata(rd0), .Done(done0), .err(err0), .busy(busy0)
    );

    mem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)
    ) u_ws0 (
        .clk(clk), .rst(rst), .R(r1), .W(w1), .addr(a1), .wdata(d1),
        .rdata(rd1), .Done(done1), .err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int sel, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            r0 = r; w0 = w; a0 = a; d0 = d;
        end else begin
            r1 = r; w1 = w; a1 = a; d1 = d;
        end
    endtask

    // One full request on instance sel; entered and left at a negedge.
    // R/W are held for 'hold' cycles after the Done cycle, then dropped.
    task automatic do_req(input int sel, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d,
                          input int hold, input string tag);
        int unsigned idx;
        bit          legal;
        int          done_c;
        logic        dn, bz, er, exp_dn;
        logic [31:0] rd, exp_rd;
        idx    = a >> 2;
        legal  = !(r && w) && (idx < 1024);
        done_c = (sel == 0) ? 3 : 1;
        if (legal && r) mdl_rd[sel] = mdl_mem[sel][idx];
        if (legal && w) mdl_mem[sel][idx] = d;
        exp_rd = mdl_rd[sel];
        drive(sel, r, w, a, d);
        for (int c = 0; c <= done_c + hold; c++) begin
            @(negedge clk);
            dn = (sel == 0) ? done0 : done1;
            bz = (sel == 0) ? busy0 : busy1;
            er = (sel == 0) ? err0  : err1;
            rd = (sel == 0) ? rd0   : rd1;
            exp_dn = (c == done_c);
            checks++;
            if (bz !== 1'b1) begin
                failures++;
                $display("FAIL %s busy cyc=%0d got=%b exp=1", tag, c, bz);
            end
            checks++;
            if (dn !== exp_dn) begin
                failures++;
                $display("FAIL %s Done cyc=%0d got=%b exp=%b", tag, c, dn, exp_dn);
            end
            if (c == done_c) begin
                checks++;
                if (er !== !legal) begin
                    failures++;
                    $display("FAIL %s err got=%b exp=%b", tag, er, !legal);
                end
                checks++;
                if (rd !== exp_rd) begin
                    failures++;
                    $display("FAIL %s rdata got=%h exp=%h", tag, rd, exp_rd);
                end
            end
        end
        drive(sel, 1'b0, 1'b0, a, d);
        @(negedge clk);
        bz = (sel == 0) ? busy0 : busy1;
        dn = (sel == 0) ? done0 : done1;
        checks++;
        if (bz !== 1'b0 || dn !== 1'b0) begin
            failures++;
            $display("FAIL %s release busy=%b Done=%b exp=0/0", tag, bz, dn);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        mdl_rd[0] = 32'h0;
        mdl_rd[1] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done0, err0, busy0, done1, err1, busy1} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {done0, err0, busy0, done1, err1, busy1});
        end
        checks++;
        if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h/%h exp=0/0", rd0, rd1);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_ws2();
        do_req(0, 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 2, "preload5");
        do_req(0, 1'b1, 1'b0, 32'h14, 32'h0, 2, "read5");
    endtask

    task automatic test_write_read();
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h12345678, 2, "wr20");
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 2, "rd20");
    endtask

    task automatic test_held();
        do_req(0, 1'b1, 1'b0, 32'h14, 32'h0, 5, "held5");
    endtask

    task automatic test_illegal();
        do_req(0, 1'b0, 1'b1, 32'h0, 32'hCAFE0001, 2, "wr0");
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 2, "rd20_again");
        do_req(0, 1'b1, 1'b1, 32'h0, 32'h55555555, 2, "ill_rw");
        do_req(0, 1'b0, 1'b1, 32'h1000, 32'hBAD0BAD0, 2, "ill_oob");
        do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 2, "rd0_kept");
    endtask

    task automatic test_ws0();
        do_req(1, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 2, "ws0_wr");
        do_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 2, "ws0_rd");
        do_req(1, 1'b1, 1'b1, 32'h40, 32'h0, 3, "ws0_ill");
    endtask

    task automatic test_async_reset();
        do_req(0, 1'b0, 1'b1, 32'h8, 32'h11111111, 2, "pre_wr8");
        // Write that must be discarded by reset during BUSY.
        drive(0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL arst_busy_before got=%b exp=1", busy0);
        end
        #2 rst = 1'b0;
        #1;
        mdl_rd[0] = 32'h0;
        mdl_rd[1] = 32'h0;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || rd0 !== 32'h0) begin
            failures++;
            $display("FAIL arst_busy busy=%b Done=%b rdata=%h exp=0/0/0", busy0, done0, rd0);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h8, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 2, "rd8_after_rst");
        // Reset while Done is high: Done must fall at once.
        drive(0, 1'b1, 1'b0, 32'h8, 32'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (done0 !== 1'b1) begin
            failures++;
            $display("FAIL arst_done_before got=%b exp=1", done0);
        end
        #2 rst = 1'b0;
        #1;
        mdl_rd[0] = 32'h0;
        mdl_rd[1] = 32'h0;
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL arst_done Done=%b busy=%b exp=0/0", done0, busy0);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h8, 32'h0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Back-to-back random traffic at minimum spacing on both instances.
    task automatic test_random();
        logic [31:0] a, d;
        bit          r, w;
        int          sel, k, o;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                do_req(s, 1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 2, "pool_wr");
            end
        end
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 9));
            if (k == 0)      a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            else if (k == 1) a = 32'hFFFF_FFF0;
            else             a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            o = int'($urandom_range(0, 5));
            r = (o == 0) || (o >= 3);
            w = (o <= 2);
            d = $urandom;
            do_req(sel, r, w, a, d, int'($urandom_range(2, 4)), "rand");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read_ws2();
        test_write_read();
        test_held();
        test_illegal();
        test_ws0();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
